// File: rtl/exc_sequencer_if.sv
// Exception sequencer bus: event inputs, PC/memory data and the
// EPC/PC/memory-override outputs. The cause/exc_count outputs exist
// only when EXC_CAUSE_EN is defined.
interface exc_sequencer_if;
   logic        exc_opcode;
   logic        exc_ovf;
   logic        exc_divz;
   logic [31:0] pc_in;
   logic [31:0] mem_data;
   logic [31:0] mem_addr;
   logic        mem_sel;
   logic        epc_we;
   logic [31:0] epc_data;
   logic        pc_we;
   logic [31:0] pc_data;
   logic        busy;
`ifdef EXC_CAUSE_EN
   logic [1:0]  cause;
   logic [7:0]  exc_count;

   modport slave (
      input  exc_opcode, exc_ovf, exc_divz, pc_in, mem_data,
      output mem_addr, mem_sel, epc_we, epc_data, pc_we, pc_data, busy,
             cause, exc_count
   );
   modport master (
      output exc_opcode, exc_ovf, exc_divz, pc_in, mem_data,
      input  mem_addr, mem_sel, epc_we, epc_data, pc_we, pc_data, busy,
             cause, exc_count
   );
`else
   modport slave (
      input  exc_opcode, exc_ovf, exc_divz, pc_in, mem_data,
      output mem_addr, mem_sel, epc_we, epc_data, pc_we, pc_data, busy
   );
   modport master (
      output exc_opcode, exc_ovf, exc_divz, pc_in, mem_data,
      input  mem_addr, mem_sel, epc_we, epc_data, pc_we, pc_data, busy
   );
`endif
endinterface

// File: rtl/exc_sequencer.sv
// Exception sequencer: on an exception event saves PC-4 to EPC, fetches
// the handler address from the cause's vector slot and loads it into PC.
// IDLE -> SAVE -> WAIT -> LOAD -> IDLE, events ignored while busy.
// Optional feature macro: EXC_CAUSE_EN (adds cause and exc_count outputs).
module exc_sequencer (
   input  logic           clk,
   input  logic           reset,
   exc_sequencer_if.slave bus
);

   typedef enum logic [1:0] {IDLE = 2'd0, SAVE = 2'd1, WAIT = 2'd2, LOAD = 2'd3} state_t;

   state_t      state, nextState;
   logic        anyEvent;
   logic [1:0]  winCause;
   logic [31:0] memAddrQ;
   logic [31:0] epcDataQ;
   logic [31:0] pcDataQ;

   // Priority resolve of simultaneous events: opcode > overflow > divz
   always_comb begin
      anyEvent = bus.exc_opcode | bus.exc_ovf | bus.exc_divz;
      winCause = 2'd3;
      if (bus.exc_opcode)   winCause = 2'd1;
      else if (bus.exc_ovf) winCause = 2'd2;
   end

   // Next-state logic; only IDLE looks at the event inputs
   always_comb begin
      nextState = state;
      case (state)
         IDLE: if (anyEvent) nextState = SAVE;
         SAVE: nextState = WAIT;
         WAIT: nextState = LOAD;
         LOAD: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Datapath: vector and EPC latched on entry, handler address kept after LOAD
   always_ff @(posedge clk) begin
      if (reset) begin
         memAddrQ <= '0;
         epcDataQ <= '0;
         pcDataQ  <= '0;
      end else begin
         if (state == IDLE && anyEvent) begin
            // vectors 253/254/255 are 0xFC + cause
            memAddrQ <= {24'h0, 6'h3F, winCause};
            epcDataQ <= bus.pc_in - 32'd4;
         end
         if (state == LOAD) pcDataQ <= {24'h0, bus.mem_data[7:0]};
      end
   end

`ifdef EXC_CAUSE_EN
   logic [1:0] causeQ;
   logic [1:0] causeOut;
   logic [7:0] excCount;

   // Cause captured on entry, published and counted while in SAVE
   always_ff @(posedge clk) begin
      if (reset) begin
         causeQ   <= '0;
         causeOut <= '0;
         excCount <= '0;
      end else begin
         if (state == IDLE && anyEvent) causeQ <= winCause;
         if (state == SAVE) begin
            causeOut <= causeQ;
            excCount <= excCount + 8'd1;
         end
      end
   end

   // Optional status outputs
   always_comb begin
      bus.cause     = causeOut;
      bus.exc_count = excCount;
   end
`endif

   // Output decode; pc_data passes memory data through during LOAD
   always_comb begin
      bus.busy     = (state != IDLE);
      bus.mem_sel  = (state != IDLE);
      bus.epc_we   = (state == SAVE);
      bus.pc_we    = (state == LOAD);
      bus.mem_addr = memAddrQ;
      bus.epc_data = epcDataQ;
      bus.pc_data  = pcDataQ;
      if (state == LOAD) bus.pc_data = {24'h0, bus.mem_data[7:0]};
   end

endmodule

// File: doc/exc_sequencer.md
EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; clk and reset SHALL be its first two ports.
REQ-002 clk  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 exc_opcode  input  1  invalid-opcode event, sampled at the clk edge.
REQ-005 exc_ovf  input  1  ALU overflow event, sampled at the clk edge.
REQ-006 exc_divz  input  1  divide-by-zero event, sampled at the clk edge.
REQ-007 pc_in  input  32  current PC value (already incremented by 4).
REQ-008 mem_data  input  32  memory read data, valid one cycle after mem_addr is presented.
REQ-009 mem_addr  output  32  exception vector address.
REQ-010 mem_sel  output  1  high while mem_addr SHALL override the CPU address mux.
REQ-011 epc_we  output  1  single-cycle EPC write strobe.
REQ-012 epc_data  output  32  value written to EPC.
REQ-013 pc_we  output  1  single-cycle PC write strobe.
REQ-014 pc_data  output  32  handler address written to PC.
REQ-015 busy  output  1  high in every state except IDLE; the control unit SHALL stall while it is high.

Function
REQ-016 The FSM states SHALL be IDLE, SAVE, WAIT and LOAD, encoded in 2 bits.
REQ-017 IDLE->SAVE SHALL occur when any event input is high at the clock edge; otherwise the FSM SHALL remain in IDLE.
REQ-018 Simultaneous events SHALL be resolved with priority exc_opcode > exc_ovf > exc_divz; the winning cause SHALL be latched on the IDLE->SAVE edge.
REQ-019 Vector address SHALL be 253 for opcode, 254 for overflow, 255 for divz, zero-extended to 32 bits.
REQ-020 In SAVE: epc_we=1, epc_data=pc_in-4 (latched at entry, 32-bit wrap-around), mem_sel=1, mem_addr=vector; the next state SHALL be WAIT.
REQ-021 In WAIT: mem_sel=1 and mem_addr held; the next state SHALL be LOAD.
REQ-022 In LOAD: pc_we=1, pc_data={24'b0, mem_data[7:0]}, mem_sel=1; the next state SHALL be IDLE.
REQ-023 Total latency SHALL be event edge -> 3 busy cycles (SAVE, WAIT, LOAD) -> IDLE; pc_we SHALL occur on the third cycle after the event edge.
REQ-024 Events arriving while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 An event sampled in the same cycle as the LOAD->IDLE transition SHALL be ignored; a new event SHALL be accepted from the first IDLE cycle.
REQ-026 In IDLE: epc_we=0, pc_we=0, mem_sel=0; mem_addr, epc_data and pc_data SHALL hold their last values.
REQ-027 epc_we and pc_we SHALL never be high in the same cycle.

Reset
REQ-028 While reset=1, state SHALL be IDLE and all outputs SHALL be 0, including mem_addr, epc_data, pc_data and busy.
REQ-029 reset asserted mid-sequence SHALL abort it on that edge with no further epc_we or pc_we.
REQ-030 reset SHALL take priority over every event input.

Configuration
REQ-031 With macro EXC_CAUSE_EN defined, the block SHALL add outputs cause (2 bits: 1=opcode, 2=ovf, 3=divz, written in SAVE) and exc_count (8 bits, incremented in SAVE, wrapping 255->0); both SHALL reset to 0.
REQ-032 Without EXC_CAUSE_EN, these ports, the cause register and the counter SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Scenario, overflow: pc_in=0x0000_0104, exc_ovf pulse, mem_data[7:0]=0x40 -> epc_we with epc_data=0x100, mem_addr=254, pc_we with pc_data=0x40 three cycles after the event.
REQ-034 Scenario, priority: exc_opcode=exc_ovf=exc_divz=1 simultaneously -> mem_addr=253 and exactly one epc_we/pc_we pair (cause=1 when EXC_CAUSE_EN is defined).
REQ-035 Scenario, ignored during busy: exc_divz held high for 6 cycles -> first sequence uses mem_addr=255, a second sequence starts in the cycle after IDLE is reached, and exactly two pc_we pulses occur.
REQ-036 Scenario, reset during sequence: reset asserted in WAIT -> no pc_we, all outputs 0 next cycle, busy=0.
REQ-037 Scenario, wrap-around: pc_in=0x0000_0000 -> epc_data=0xFFFF_FFFC.
REQ-038 Scenario, counter wrap (EXC_CAUSE_EN defined): 256 overflow events -> exc_count returns to 0.
